jk_seq_driver: RTL and testbench

- Synthesizable driver and checker for a bank of JK flip-flops; the inverse of the flop's behaviour.
- Holds a programmed sequence of target states.
- For each step, computes the J/K excitation that moves the bank from its current state to the next target, drives it for one clock, then checks the fed-back Q against the target.
- Sits beside a JKFF bank as on-chip stimulus and self-check.

---
 rtl/jk_seq_pkg.sv | 15 +
 rtl/jk_excite.sv | 22 ++
 rtl/jk_seq_driver.sv | 152 +++++++++++++++
 tb/tb_jk_seq_driver.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared state encoding and excitation-mode constants
// for the JK sequence driver and its excitation helper.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MODE_SR     = 0;
    localparam int MODE_TOGGLE = 1;

endpackage

// File: rtl/jk_excite.sv
// jk_excite: per-bit J/K excitation that moves a JK bank from cur to tgt.
// Ports: cur/tgt (WIDTH) present and wanted state, mode (0 set/reset,
// 1 toggle); J/K (WIDTH) the excitation. Purely combinational.
module jk_excite #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    input  logic             mode,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K
);

    logic [WIDTH-1:0] w_chg;

    // Only bits that must change get any drive; set/reset picks the
    // side by direction, toggle drives both inputs.
    assign w_chg = cur ^ tgt;
    assign J     = mode ? w_chg : (w_chg & tgt);
    assign K     = mode ? w_chg : (w_chg & cur);

endmodule

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: steps a JK flop bank through a stored sequence of targets,
// driving the J/K excitation for one cycle and then checking Q.
// Ports: clk, Clear (async active-low); load_en/load_addr/load_data write
// the sequence; seq_len/loop_en/start/stop control a run; q_fb is the bank
// Q; J/K drive the bank; busy/done/mismatch/err_count/step_idx report.
module jk_seq_driver
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int MODE  = MODE_SR,
    parameter int ERR_W = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             Clear,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [AW:0]      seq_len,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [AW-1:0]    step_idx
);

    localparam logic LP_TOGGLE = 1'(MODE == MODE_TOGGLE);

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_len;
    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_mm;
    logic [ERR_W-1:0] r_err;

    logic             w_busy;
    logic             w_wr;
    logic             w_last;
    logic             w_bad;
    logic [AW-1:0]    w_nidx;
    logic [AW-1:0]    w_tidx;
    logic [WIDTH-1:0] w_tgt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    assign w_busy = (r_state == DRIVE) || (r_state == CHECK);
    assign w_wr   = load_en && !w_busy;

    // Last step of the programmed sequence: idx + 1 >= len.
    assign w_last = ({1'b0, r_idx} + (AW+1)'(1)) >= r_len;
    assign w_nidx = w_last ? '0 : r_idx + AW'(1);

    // Next target index: entry 0 when launching from IDLE or wrapping,
    // otherwise the following entry.
    assign w_tidx = (r_state == CHECK) ? w_nidx : '0;

    // A write landing in the same cycle as start must be seen by step 0.
    assign w_tgt = (w_wr && (load_addr == w_tidx)) ? load_data
                                                   : r_mem[w_tidx];

    assign w_bad = q_fb != r_mem[r_idx];

    // Excitation is taken from q_fb directly: at every edge that loads
    // J/K, q_fb is exactly the resynchronised current state.
    jk_excite #(
        .WIDTH (WIDTH)
    ) u_exc (
        .cur  (q_fb),
        .tgt  (w_tgt),
        .mode (LP_TOGGLE),
        .J    (w_j),
        .K    (w_k)
    );

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_mm    <= 1'b0;
            r_err   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mm  <= 1'b0;
                        r_err <= '0;
                        r_len <= seq_len;
                        if (seq_len == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= DRIVE;
                            r_idx   <= '0;
                            r_j     <= w_j;
                            r_k     <= w_k;
                        end
                    end
                end
                DRIVE: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= CHECK;
                end
                CHECK: begin
                    if (w_bad) begin
                        r_mm <= 1'b1;
                        if (r_err != '1) begin
                            r_err <= r_err + ERR_W'(1);
                        end
                    end
                    if (!w_last || (loop_en && !stop)) begin
                        r_idx   <= w_nidx;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_state <= DRIVE;
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign J         = r_j;
    assign K         = r_k;
    assign busy      = w_busy;
    assign done      = r_state == DONE;
    assign mismatch  = r_mm;
    assign err_count = r_err;
    assign step_idx  = r_idx;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: a set/reset and a toggle instance each drive a
// behavioural JK bank; a reference model fills per-DUT scoreboards.
module tb_jk_seq_driver;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int AW = 3;

    typedef struct {
        bit         fin;
        logic [W-1:0] j;
        logic [W-1:0] k;
        int         idx;
        int         err;
        int         n;
    } exp_t;

    logic          clk       = 1'b0;
    logic          Clear     = 1'b0;
    logic          load_en   = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [W-1:0]  load_data = '0;
    logic [AW:0]   seq_len   = '0;
    logic          loop_en   = 1'b0;
    logic          start     = 1'b0;
    logic          stop      = 1'b0;
    logic [W-1:0]  stuck     = '0;
    logic          bank_ld   = 1'b0;
    logic [W-1:0]  bank_val  = '0;

    wire [W-1:0]  qf [2];
    wire [W-1:0]  jw [2];
    wire [W-1:0]  kw [2];
    wire          bw [2];
    wire          dw [2];
    wire          mw [2];
    wire [7:0]    ew [2];
    wire [AW-1:0] iw [2];

    logic [W-1:0] mdl_mem [D];
    exp_t eq0[$];
    exp_t eq1[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit fin_req = 1'b0;
    bit fin_ack = 1'b0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        logic [W-1:0] bq = '0;

        jk_seq_driver #(
            .WIDTH (W),
            .DEPTH (D),
            .MODE  (m),
            .ERR_W (8)
        ) u_dut (
            .clk       (clk),
            .Clear     (Clear),
            .load_en   (load_en),
            .load_addr (load_addr),
            .load_data (load_data),
            .seq_len   (seq_len),
            .loop_en   (loop_en),
            .start     (start),
            .stop      (stop),
            .q_fb      (bq),
            .J         (jw[m]),
            .K         (kw[m]),
            .busy      (bw[m]),
            .done      (dw[m]),
            .mismatch  (mw[m]),
            .err_count (ew[m]),
            .step_idx  (iw[m])
        );

        // Behavioural JK bank: Q+ = J~Q | ~KQ, with optional stuck-at-0 bits.
        always @(posedge clk) begin
            if (bank_ld) bq <= bank_val & ~stuck;
            else bq <= ((jw[m] & ~bq) | (~kw[m] & bq)) & ~stuck;
        end

        assign qf[m] = bq;
    end

    function automatic int qsize(int m);
        return (m == 0) ? eq0.size() : eq1.size();
    endfunction

    function automatic bit qfin(int m);
        return (m == 0) ? eq0[0].fin : eq1[0].fin;
    endfunction

    function automatic exp_t qpop(int m);
        return (m == 0) ? eq0.pop_front() : eq1.pop_front();
    endfunction

    task automatic qpush(int m, exp_t e);
        if (m == 0) eq0.push_back(e);
        else eq1.push_back(e);
    endtask

    task automatic cmp(string nm, int m, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h want %0h @%0t", nm, m, act, want, $time);
        end
    endtask

    task automatic flag(string nm, int m);
        n_cmp++;
        n_bad++;
        $display("FAIL %s dut%0d: got event want none @%0t", nm, m, $time);
    endtask

    // Monitor: pops the scoreboard on every DRIVE cycle and done pulse.
    bit   pb [2];
    bit   pd [2];
    int   bc [2];
    bit   dv;
    exp_t me;

    always begin
        @(negedge clk or negedge Clear);
        if (!Clear) begin
            #1;
            for (int m = 0; m < 2; m++) begin
                cmp("rst_J", m, 32'(jw[m]), 0);
                cmp("rst_K", m, 32'(kw[m]), 0);
                cmp("rst_busy", m, 32'(bw[m]), 0);
                cmp("rst_done", m, 32'(dw[m]), 0);
                cmp("rst_mismatch", m, 32'(mw[m]), 0);
                cmp("rst_err_count", m, 32'(ew[m]), 0);
                cmp("rst_step_idx", m, 32'(iw[m]), 0);
                if (m == 0) eq0.delete();
                else eq1.delete();
                pb[m] = 1'b0;
                pd[m] = 1'b0;
                bc[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (bw[m]) begin
                    dv = pb[m] ? !pd[m] : 1'b1;
                    bc[m]++;
                    if (dv) begin
                        if (qsize(m) == 0 || qfin(m)) begin
                            flag("drive_unexpected", m);
                        end else begin
                            me = qpop(m);
                            cmp("drive_J", m, 32'(jw[m]), 32'(me.j));
                            cmp("drive_K", m, 32'(kw[m]), 32'(me.k));
                            cmp("step_idx", m, 32'(iw[m]), me.idx);
                        end
                    end else begin
                        cmp("check_J", m, 32'(jw[m]), 0);
                        cmp("check_K", m, 32'(kw[m]), 0);
                    end
                    if (dw[m]) flag("done_while_busy", m);
                end else begin
                    dv = 1'b0;
                    cmp("idle_J", m, 32'(jw[m]), 0);
                    cmp("idle_K", m, 32'(kw[m]), 0);
                    if (dw[m]) begin
                        if (qsize(m) == 0 || !qfin(m)) begin
                            flag("done_unexpected", m);
                        end else begin
                            me = qpop(m);
                            cmp("err_count", m, 32'(ew[m]), me.err);
                            cmp("mismatch", m, 32'(mw[m]), 32'(me.err != 0));
                            cmp("busy_cycles", m, bc[m], 2 * me.n);
                            cmp("done_after_busy", m, 32'(pb[m]), 32'(me.n > 0));
                        end
                        bc[m] = 0;
                    end
                end
                pb[m] = bw[m];
                pd[m] = dv;
            end
            if (fin_req && !fin_ack) begin
                cmp("leftover", 0, qsize(0), 0);
                cmp("leftover", 1, qsize(1), 0);
                fin_ack = 1'b1;
            end
        end
    end

    // Reference model: walks the step sequence bit by bit, applying the
    // wanted excitation to an ideal JK bank with the same stuck mask.
    task automatic predict(int m, int len, bit lp, bit [63:0] mk, output int n);
        logic [W-1:0] q;
        logic [W-1:0] t;
        exp_t e;
        int idx;
        int err;
        q   = qf[m];
        err = 0;
        n   = 0;
        idx = 0;
        while (len > 0 && n < 64) begin
            t = mdl_mem[idx];
            e = '{default: 0};
            e.idx = idx;
            for (int b = 0; b < W; b++) begin
                if (q[b] == t[b]) begin
                    e.j[b] = 1'b0;
                    e.k[b] = 1'b0;
                end else if (m == 1) begin
                    e.j[b] = 1'b1;
                    e.k[b] = 1'b1;
                end else begin
                    e.j[b] = t[b];
                    e.k[b] = !t[b];
                end
                if (e.j[b] && e.k[b]) q[b] = !q[b];
                else if (e.j[b]) q[b] = 1'b1;
                else if (e.k[b]) q[b] = 1'b0;
            end
            q = q & ~stuck;
            if (q != t && err < 255) err++;
            qpush(m, e);
            n++;
            if (idx < len - 1) idx++;
            else if (lp && !mk[n-1]) idx = 0;
            else break;
        end
        e = '{default: 0};
        e.fin = 1'b1;
        e.err = err;
        e.n   = n;
        qpush(m, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int a, int d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = W'(d);
        mdl_mem[a] = W'(d);
        tick();
        load_en = 1'b0;
    endtask

    task automatic set_bank(int v);
        bank_val = W'(v);
        bank_ld  = 1'b1;
        tick();
        bank_ld  = 1'b0;
    endtask

    task automatic run(int len, bit lp, bit [63:0] mk, bit noise,
                       bit sl, int sa, int sd, int clr_at);
        int n;
        int n1;
        if (sl) begin
            load_en   = 1'b1;
            load_addr = AW'(sa);
            load_data = W'(sd);
            mdl_mem[sa] = W'(sd);
        end
        predict(0, len, lp, mk, n);
        predict(1, len, lp, mk, n1);
        seq_len = (AW+1)'(len);
        loop_en = lp;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        for (int c = 1; c <= 2 * n + 1; c++) begin
            if (c == clr_at) begin
                Clear = 1'b0;
                #2;
                Clear = 1'b1;
                break;
            end
            stop = 1'b0;
            if ((c % 2) == 0) stop = mk[c/2-1];
            else if (noise) stop = 1'($urandom_range(0, 1));
            tick();
        end
        stop = 1'b0;
        for (int k = 0; k < 40 && (bw[0] || bw[1] || dw[0] || dw[1]); k++) tick();
        if (bw[0] || bw[1]) begin
            Clear = 1'b0;
            #2;
            Clear = 1'b1;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len;
        int ca;
        int se;
        bit lp;
        bit [63:0] mk;

        // Held in reset with random inputs; the monitor checks all outputs.
        for (int i = 0; i < 6; i++) begin
            load_en   = 1'($urandom_range(0, 1));
            load_addr = AW'($urandom);
            load_data = W'($urandom);
            seq_len   = (AW+1)'($urandom_range(0, 8));
            loop_en   = 1'($urandom_range(0, 1));
            start     = 1'($urandom_range(0, 1));
            stop      = 1'($urandom_range(0, 1));
            tick();
        end
        load_en = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        Clear   = 1'b1;
        tick();

        load(0, 4'b0001);
        load(1, 4'b0011);
        load(2, 4'b0010);
        load(3, 4'b0000);
        set_bank(0);
        run(4, 0, 0, 0, 0, 0, 0, -1);

        stuck = 4'b0001;
        set_bank(0);
        run(4, 0, 0, 0, 0, 0, 0, -1);
        stuck = 4'b0000;
        set_bank(0);

        run(0, 0, 0, 0, 0, 0, 0, -1);
        // stop at step 2 (not a last step) is ignored; step 3 ends the loop
        run(2, 1, 64'hC, 1, 0, 0, 0, -1);

        set_bank(0);
        run(4, 0, 0, 0, 0, 0, 0, 3);
        run(4, 0, 0, 0, 0, 0, 0, -1);

        // start together with a write to entry 0
        run(1, 0, 0, 0, 1, 0, 4'b1010, -1);

        for (int i = 0; i < D; i++) load(i, $urandom_range(0, 15));
        repeat (40) begin
            repeat ($urandom_range(0, 2)) load($urandom_range(0, D-1), $urandom_range(0, 15));
            stuck = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            set_bank($urandom_range(0, 15));
            len = $urandom_range(0, D);
            lp  = 1'($urandom_range(0, 1));
            mk  = '0;
            if (lp && len > 0) begin
                se = $urandom_range(1, 3) * len - 1;
                mk = {$urandom, $urandom} & {$urandom, $urandom} & ((64'd1 << se) - 64'd1);
                mk[se] = 1'b1;
            end
            ca = -1;
            if (len > 0 && $urandom_range(0, 7) == 0) ca = $urandom_range(1, 2 * len);
            run(len, lp, mk, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), $urandom_range(0, D-1),
                $urandom_range(0, 15), ca);
        end

        fin_req = 1'b1;
        for (int k = 0; k < 10 && !fin_ack; k++) tick();
        if (!fin_ack) begin
            $display("FAIL fin_handshake: got no monitor response want response");
            $fatal(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
